// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader in front of the processor's program memory. A framed byte
// stream (16-bit word count N, 4N data bytes, 1 XOR checksum byte) arrives over
// a valid/ready handshake. The loader assembles big-endian 32-bit words and
// writes them sequentially starting at BASE_ADDRESS. The core is held in reset
// until a complete frame with a matching checksum has been written.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   start_i         begin a load (honoured in IDLE, DONE and ERROR only)
//   rx_data_i       stream byte
//   rx_valid_i      rx_data_i is valid
//   rx_ready_o      loader accepts a byte this cycle
//   mem_write_o     one-cycle program memory write strobe
//   mem_address_o   byte address of the word being written
//   mem_data_o      word being written
//   core_reset_n_o  active-low core reset, released only in DONE
//   busy_o          load in progress
//   done_o          load completed with a good checksum
//   error_o         bad length or bad checksum
//   words_loaded_o  words written in the current load
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        core_reset_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CSUM   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    localparam logic [15:0] MAX_WORDS = 16'(MEMORY_DEPTH);

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_words;
    logic [31:0] r_word;
    logic [31:0] r_addr;
    logic [7:0]  r_csum;
    logic [1:0]  r_byte_idx;

    logic        w_xfer;
    logic [15:0] w_len_full;
    logic [15:0] w_words_next;

    // Every output is a decode of registered state or a register itself, so
    // neither start_i nor rx_valid_i can reach an output combinationally.
    assign rx_ready_o     = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                            (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign busy_o         = rx_ready_o || (r_state == ST_WRITE);
    assign mem_write_o    = (r_state == ST_WRITE);
    assign done_o         = (r_state == ST_DONE);
    assign error_o        = (r_state == ST_ERROR);
    assign core_reset_n_o = (r_state == ST_DONE);
    assign mem_address_o  = r_addr;
    assign mem_data_o     = r_word;
    assign words_loaded_o = r_words;

    assign w_xfer       = rx_valid_i && rx_ready_o;
    // Full length as it will be once the LSB byte on the bus is latched.
    assign w_len_full   = {r_len[15:8], rx_data_i};
    assign w_words_next = r_words + 16'd1;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_words    <= '0;
            r_word     <= '0;
            r_addr     <= BASE_ADDRESS;
            r_csum     <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        r_state    <= ST_LEN_HI;
                        r_words    <= '0;
                        r_csum     <= '0;
                        r_byte_idx <= '0;
                        r_addr     <= BASE_ADDRESS;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= rx_data_i;
                        r_state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= rx_data_i;
                        if ((w_len_full == 16'd0) || (w_len_full > MAX_WORDS)) begin
                            r_state <= ST_ERROR;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        // Shift left so the first byte of a word ends in [31:24].
                        r_word     <= {r_word[23:0], rx_data_i};
                        r_csum     <= r_csum ^ rx_data_i;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Strobe is visible this cycle with the current address;
                    // address and count advance for the next word.
                    r_words <= w_words_next;
                    r_addr  <= r_addr + 32'd4;
                    r_state <= (w_words_next == r_len) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (w_xfer) begin
                        r_state <= (rx_data_i == r_csum) ? ST_DONE : ST_ERROR;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Frames are built from a word list and
// the expected memory writes and final status are derived from the frame rules
// (address = BASE + 4k, status from length range and XOR checksum).
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        core_reset_n_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] words_loaded_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    program_loader #(
        .MEMORY_DEPTH(DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .core_reset_n_o(core_reset_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk = ~clk;

    // Record every write strobe; the source must never be offered ready while
    // a write is in progress.
    always @(negedge clk) begin
        if (mem_write_o === 1'b1) begin
            got_addr.push_back(mem_address_o);
            got_data.push_back(mem_data_o);
            checks++;
            if (rx_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: rx_ready_o=%b required 0", rx_ready_o);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic drive_bytes(input logic [7:0] q[$], input int valid_pct, output int cycles);
        int   idx = 0;
        logic xfer;
        cycles = 0;
        while (idx < q.size() && cycles < 4000) begin
            rx_valid_i = ($urandom_range(0, 99) < valid_pct);
            rx_data_i  = rx_valid_i ? q[idx] : 8'($urandom);
            @(negedge clk);
            xfer = rx_valid_i && rx_ready_o;
            @(posedge clk); #1;
            cycles++;
            if (xfer) idx++;
        end
        rx_valid_i = 1'b0;
        checks++;
        if (idx != q.size()) begin
            errors++;
            $display("FAIL drive_timeout: accepted=%0d required=%0d", idx, q.size());
        end
    endtask

    // One complete load compared against the frame rules.
    task automatic run_load(input logic [15:0] n, input logic [31:0] words[$],
                            input bit bad_csum, input int valid_pct, input string tag);
        logic [7:0]  q[$];
        logic [7:0]  csum = 8'h00;
        logic [31:0] w;
        bit          len_ok;
        int          exp_writes;
        bit          exp_done;
        int          cyc;
        len_ok = (n != 16'd0) && (int'(n) <= DEPTH);
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        if (len_ok) begin
            for (int k = 0; k < int'(n); k++) begin
                w = words[k];
                for (int b = 3; b >= 0; b--) begin
                    q.push_back(w[b*8 +: 8]);
                    csum ^= w[b*8 +: 8];
                end
            end
            q.push_back(bad_csum ? (csum ^ 8'h5A) : csum);
        end
        exp_writes = len_ok ? int'(n) : 0;
        exp_done   = len_ok && !bad_csum;

        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_bytes(q, valid_pct, cyc);

        checks++;
        if (got_addr.size() != exp_writes) begin
            errors++;
            $display("FAIL %s write_count: got=%0d required=%0d", tag, got_addr.size(), exp_writes);
        end
        for (int k = 0; k < exp_writes && k < got_addr.size(); k++) begin
            checks++;
            if (got_addr[k] !== BASE + 32'(4 * k) || got_data[k] !== words[k]) begin
                errors++;
                $display("FAIL %s write[%0d]: got %h@%h required %h@%h", tag, k,
                         got_data[k], got_addr[k], words[k], BASE + 32'(4 * k));
            end
        end
        checks++;
        if (done_o !== exp_done || error_o !== !exp_done || core_reset_n_o !== exp_done ||
            busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s status: done=%b error=%b core_rst_n=%b busy=%b required done=%b error=%b core_rst_n=%b busy=0",
                     tag, done_o, error_o, core_reset_n_o, busy_o, exp_done, !exp_done, exp_done);
        end
        checks++;
        if (words_loaded_o !== 16'(exp_writes)) begin
            errors++;
            $display("FAIL %s words_loaded: got=%0d required=%0d", tag, words_loaded_o, exp_writes);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (rx_ready_o !== 1'b0 || mem_write_o !== 1'b0 || mem_address_o !== BASE ||
            mem_data_o !== 32'h0 || core_reset_n_o !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || error_o !== 1'b0 || words_loaded_o !== 16'h0) begin
            errors++;
            $display("FAIL %s: rdy=%b wr=%b addr=%h data=%h crn=%b busy=%b done=%b err=%b words=%0d required all zero, addr=%h",
                     tag, rx_ready_o, mem_write_o, mem_address_o, mem_data_o, core_reset_n_o,
                     busy_o, done_o, error_o, words_loaded_o, BASE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        logic [7:0] q[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h01, 8'h09, 8'h40, 8'h20, 8'h45};
        int cyc;
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_bytes(q, 100, cyc);
        // start cycle + 13 streaming cycles = 14 cycles to done_o
        checks++;
        if (cyc + 1 != 14) begin
            errors++;
            $display("FAIL nominal_latency: got=%0d cycles required=14", cyc + 1);
        end
        checks++;
        if (got_addr.size() != 2) begin
            errors++;
            $display("FAIL nominal_write_count: got=%0d required=2", got_addr.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'h2008_0005 || got_addr[0] !== 32'h0 ||
                got_data[1] !== 32'h0109_4020 || got_addr[1] !== 32'h4) begin
                errors++;
                $display("FAIL nominal_writes: got %h@%h %h@%h required 20080005@0 01094020@4",
                         got_data[0], got_addr[0], got_data[1], got_addr[1]);
            end
        end
        checks++;
        if (done_o !== 1'b1 || core_reset_n_o !== 1'b1 || error_o !== 1'b0 ||
            words_loaded_o !== 16'd2) begin
            errors++;
            $display("FAIL nominal_status: done=%b crn=%b err=%b words=%0d required 1 1 0 2",
                     done_o, core_reset_n_o, error_o, words_loaded_o);
        end
    endtask

    task automatic test_bad_checksum();
        logic [31:0] w[$] = '{32'h2008_0005, 32'h0109_4020};
        run_load(16'd2, w, 1'b1, 100, "bad_csum");
    endtask

    task automatic test_length_bounds();
        logic [31:0] w[$];
        run_load(16'h0000, w, 1'b0, 100, "len_zero");
        run_load(16'h0021, w, 1'b0, 100, "len_33");
        run_load(16'h0120, w, 1'b0, 100, "len_288");
        for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
        run_load(16'h0020, w, 1'b0, 100, "len_32");
        checks++;
        if (got_addr.size() != DEPTH || got_addr[got_addr.size() - 1] !== BASE + 32'h7C) begin
            errors++;
            $display("FAIL len_32_last_addr: got=%h required=%h",
                     (got_addr.size() > 0) ? got_addr[got_addr.size() - 1] : 32'hx, BASE + 32'h7C);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[$] = '{32'h2008_0005, 32'h0109_4020};
        run_load(16'd2, w, 1'b0, 50, "bp_nominal");
        for (int it = 0; it < 6; it++) begin
            logic [31:0] rw[$];
            logic [15:0] n;
            bit          bad;
            n   = 16'($urandom_range(1, DEPTH));
            bad = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < int'(n); k++) rw.push_back($urandom);
            run_load(n, rw, bad, $urandom_range(30, 90), $sformatf("bp_rand%0d", it));
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0]  q[$] = '{8'h00, 8'h02, 8'h20, 8'h08};
        logic [31:0] w[$] = '{32'h2008_0005, 32'h0109_4020};
        int cyc;
        pulse_start();
        drive_bytes(q, 100, cyc);
        reset = 1'b0;
        #1;
        check_reset_values("reset_mid_word");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || rx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_autostart: busy=%b ready=%b required 0 0", busy_o, rx_ready_o);
        end
        run_load(16'd2, w, 1'b0, 100, "after_reset");
    endtask

    task automatic test_reload();
        logic [31:0] w[$] = '{32'h2008_0005, 32'h0109_4020};
        logic [7:0]  q[$] = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        int cyc;
        run_load(16'd2, w, 1'b0, 100, "reload_first");
        got_addr.delete();
        got_data.delete();
        pulse_start();
        checks++;
        if (core_reset_n_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_entry: crn=%b done=%b busy=%b required 0 0 1",
                     core_reset_n_o, done_o, busy_o);
        end
        drive_bytes(q, 100, cyc);
        checks++;
        if (got_addr.size() != 1 || got_data[0] !== 32'hAABB_CCDD || got_addr[0] !== 32'h0) begin
            errors++;
            $display("FAIL reload_write: count=%0d required 1 AABBCCDD@0", got_addr.size());
        end
        checks++;
        if (done_o !== 1'b1 || core_reset_n_o !== 1'b1 || words_loaded_o !== 16'd1) begin
            errors++;
            $display("FAIL reload_status: done=%b crn=%b words=%0d required 1 1 1",
                     done_o, core_reset_n_o, words_loaded_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_length_bounds();
        test_backpressure();
        test_reset_mid_word();
        test_reload();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the processor's program memory. It receives a program as a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into program memory. It holds the processor core in reset until a complete frame with a correct checksum has been written, then releases it.

## Interface
Parameters:
- MEMORY_DEPTH, 32, program memory capacity in 32-bit words; this is the maximum accepted word count.
- BASE_ADDRESS, 32'h0000_0000, byte address of word 0; word k is written at BASE_ADDRESS + 4k.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  begin a load; sampled only in IDLE, DONE or ERROR.
- rx_data_i  input  8  stream byte.
- rx_valid_i  input  1  rx_data_i is valid.
- rx_ready_o  output  1  loader can accept a byte; transfer when rx_valid_i && rx_ready_o at a rising edge.
- mem_write_o  output  1  one-cycle write strobe to program memory.
- mem_address_o  output  32  byte address of the word being written.
- mem_data_o  output  32  word being written.
- core_reset_n_o  output  1  active-low reset to the processor core; 1 only in DONE.
- busy_o  output  1  high in LEN_HI, LEN_LO, DATA, WRITE, CSUM.
- done_o  output  1  high in DONE.
- error_o  output  1  high in ERROR.
- words_loaded_o  output  16  count of words written in the current load.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, MSB first), then 4N data bytes (each word MSB first), then 1 checksum byte = XOR of all 4N data bytes (length bytes excluded).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE: start_i -> LEN_HI; clears words_loaded_o, checksum accumulator, byte index; sets mem_address_o = BASE_ADDRESS.
- LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
- LEN_LO: on transfer, latch N[7:0]; if N == 0 or N > MEMORY_DEPTH -> ERROR, else -> DATA.
- DATA: on each transfer, shift byte into the word register (first byte lands in [31:24]) and XOR into the accumulator; after the 4th byte -> WRITE.
- WRITE: mem_write_o = 1 for exactly one cycle, with mem_data_o = assembled word and mem_address_o = BASE_ADDRESS + 4*words_loaded_o. At the end of the cycle words_loaded_o increments and mem_address_o advances by 4. Next state is CSUM if words_loaded_o (new) == N, else DATA.
- CSUM: on transfer, byte == accumulator -> DONE, else -> ERROR.
- DONE: core_reset_n_o = 1. start_i -> LEN_HI (reload) and core_reset_n_o drops the following cycle.
- ERROR: core_reset_n_o stays 0. start_i -> LEN_HI. Words already written are not rolled back.
- start_i is ignored while busy_o = 1.
- rx_ready_o = 1 only in LEN_HI, LEN_LO, DATA and CSUM. It is 0 in IDLE, WRITE, DONE and ERROR.
- Arithmetic: the address adds in 32 bits and wraps modulo 2^32. The word count compare is unsigned 16-bit.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from rx_valid_i or start_i to any output.
- Reset values (asynchronous, while reset = 0):
  - state IDLE
  - rx_ready_o 0, mem_write_o 0
  - mem_address_o BASE_ADDRESS, mem_data_o 0
  - core_reset_n_o 0, busy_o 0, done_o 0, error_o 0
  - words_loaded_o 0
- Reset asserted mid-load aborts immediately; any in-progress write strobe is removed. The next load needs a new start_i.
- With rx_valid_i held high, the load takes 1 cycle (start), 2 (length), 5 per word (4 bytes + WRITE) and 1 (checksum): N = 2 takes 14 cycles from start_i to done_o.
- done_o and core_reset_n_o rise in the cycle after the checksum transfer.
- error_o rises in the cycle after the offending length-LSB or checksum transfer.
- Input bytes presented during WRITE are held by the source (ready is low). They are neither lost nor duplicated.

## Test plan
- Nominal, BASE_ADDRESS 0: start, bytes 00 02 20 08 00 05 01 09 40 20 45 -> writes 0x20080005 @0x0 and 0x01094020 @0x4, one strobe each. Then done_o = 1, core_reset_n_o = 1, words_loaded_o = 2.
- Bad checksum: same frame with last byte 0x44 -> both writes occur, error_o = 1, core_reset_n_o = 0, done_o = 0.
- Length bounds, MEMORY_DEPTH = 32:
  - N = 0x0000 -> ERROR after LEN_LO, zero writes.
  - N = 0x0021 -> ERROR after LEN_LO, zero writes.
  - N = 0x0020 with a valid frame -> 32 writes, last at 0x7C, DONE.
- Backpressure: rx_valid_i toggled randomly across the nominal frame -> rx_ready_o = 0 in every WRITE cycle. Identical memory writes and DONE result; no byte skipped or repeated.
- Reset mid-word: drop reset after the 2nd data byte -> all outputs at reset values immediately. Then run start plus the nominal frame -> correct DONE.
- Reload: in DONE pulse start_i -> core_reset_n_o = 0 and done_o = 0 next cycle, busy_o = 1. A second frame with N = 1 (word 0xAABBCCDD, checksum 0x00) -> write @0x0, DONE, words_loaded_o = 1.
